// File: rtl/alu_8bit.sv
// alu_8bit: 8-bit, 16-operation ALU with registered result and carry flag.
// Operands and opcode are sampled on every rising clock edge, and the result
// appears one cycle later. The datapath is purely combinational up to the
// output registers. Reset is asynchronous and active-low.
module alu_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] ALU_Sel,
  output logic [7:0] ALU_Out,
  output logic       CarryOut
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } op_t;

  op_t        op;
  logic [8:0] sum;
  logic [7:0] result;

  assign op  = op_t'(ALU_Sel);

  // The carry is always the carry of A+B, whatever the opcode.
  assign sum = {1'b0, A} + {1'b0, B};

  // Select the result of the requested operation.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = sum[7:0];
      OP_SUB:  result = A - B;
      OP_MUL:  result = A * B;
      OP_DIV:  result = (B == 8'h00) ? 8'hFF : A / B;
      OP_SHL:  result = {A[6:0], 1'b0};
      OP_SHR:  result = {1'b0, A[7:1]};
      OP_ROL:  result = {A[6:0], A[7]};
      OP_ROR:  result = {A[0], A[7:1]};
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_NAND: result = ~(A & B);
      OP_XNOR: result = ~(A ^ B);
      OP_GT:   result = (A > B) ? 8'h01 : 8'h00;
      OP_EQ:   result = (A == B) ? 8'h01 : 8'h00;
      default: result = '0;
    endcase
  end

  // Output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_Out  <= '0;
      CarryOut <= 1'b0;
    end else begin
      ALU_Out  <= result;
      CarryOut <= sum[8];
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: self-checking bench for alu_8bit with directed vectors and a
// randomized back-to-back run checked against an arithmetic reference model.
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       CarryOut;

  int tests;
  int fails;

  alu_8bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result computed with plain integer arithmetic.
  function automatic logic [7:0] model_out(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] sel);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    case (int'(sel))
      0:  r = (ia + ib) % 256;
      1:  r = (ia - ib + 256) % 256;
      2:  r = (ia * ib) % 256;
      3:  r = (ib == 0) ? 255 : ia / ib;
      4:  r = (ia * 2) % 256;
      5:  r = ia / 2;
      6:  r = (ia * 2) % 256 + ia / 128;
      7:  r = ia / 2 + (ia % 2) * 128;
      8:  r = int'(a & b);
      9:  r = int'(a | b);
      10: r = int'(a ^ b);
      11: r = 255 - int'(a | b);
      12: r = 255 - int'(a & b);
      13: r = 255 - int'(a ^ b);
      14: r = (ia > ib) ? 1 : 0;
      15: r = (ia == ib) ? 1 : 0;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  function automatic logic model_carry(input logic [7:0] a, input logic [7:0] b);
    return (int'(a) + int'(b)) > 255;
  endfunction

  // Drive operands a little after a rising edge, then wait until just after the next.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    A       = a;
    B       = b;
    ALU_Sel = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] exp_o;
    logic       exp_c;
    rst_n   = 1'b0;
    A       = 8'h0A;
    B       = 8'h02;
    ALU_Sel = 4'd0;
    #3;
    tests++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b0) begin
      fails++;
      $display("FAIL reset_initial: out=%h carry=%b expected 00/0", ALU_Out, CarryOut);
    end
    @(posedge clk); #1;
    tests++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b0) begin
      fails++;
      $display("FAIL reset_held_edge: out=%h carry=%b expected 00/0", ALU_Out, CarryOut);
    end
    #2 rst_n = 1'b1;
    #1;
    tests++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b0) begin
      fails++;
      $display("FAIL reset_after_release: out=%h carry=%b expected 00/0", ALU_Out, CarryOut);
    end
    @(posedge clk); #1;
    tests++;
    if (ALU_Out !== 8'h0C || CarryOut !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_result: out=%h carry=%b expected 0c/0", ALU_Out, CarryOut);
    end
    // Mid-stream reset with a nonzero, carry-setting result on the outputs.
    apply(8'hF6, 8'h0B, 4'd0);
    tests++;
    if (ALU_Out !== 8'h01 || CarryOut !== 1'b1) begin
      fails++;
      $display("FAIL reset_pre_value: out=%h carry=%b expected 01/1", ALU_Out, CarryOut);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b0) begin
      fails++;
      $display("FAIL reset_async_clear: out=%h carry=%b expected 00/0", ALU_Out, CarryOut);
    end
    @(posedge clk); #1;
    A       = 8'h55;
    B       = 8'hC3;
    ALU_Sel = 4'd10;
    #2 rst_n = 1'b1;
    #1;
    tests++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold_release: out=%h carry=%b expected 00/0", ALU_Out, CarryOut);
    end
    @(posedge clk); #1;
    exp_o = model_out(8'h55, 8'hC3, 4'd10);
    exp_c = model_carry(8'h55, 8'hC3);
    tests++;
    if (ALU_Out !== exp_o || CarryOut !== exp_c) begin
      fails++;
      $display("FAIL reset_mid_first: out=%h carry=%b expected %h/%b", ALU_Out, CarryOut, exp_o, exp_c);
    end
  endtask

  task automatic test_opcode_sweep;
    logic [7:0] exp_tab [16];
    exp_tab = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
    for (int i = 0; i < 16; i++) begin
      apply(8'h0A, 8'h02, 4'(i));
      tests++;
      if (ALU_Out !== exp_tab[i] || CarryOut !== 1'b0) begin
        fails++;
        $display("FAIL sweep_sel%0d: out=%h carry=%b expected %h/0", i, ALU_Out, CarryOut, exp_tab[i]);
      end
    end
  endtask

  task automatic test_edges;
    logic [7:0] va   [13];
    logic [7:0] vb   [13];
    logic [3:0] vs   [13];
    logic [7:0] vo   [13];
    logic       vc   [13];
    va = '{8'hF6, 8'hF6, 8'hF6, 8'hF6, 8'hF6, 8'h37, 8'h80, 8'h80, 8'h80, 8'h00, 8'h81, 8'h00, 8'hFF};
    vb = '{8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h00, 8'h80, 8'h80, 8'h80, 8'h01, 8'h00, 8'h00, 8'h01};
    vs = '{4'd0,  4'd1,  4'd6,  4'd4,  4'd14, 4'd3,  4'd15, 4'd14, 4'd0,  4'd1,  4'd7,  4'd3,  4'd15};
    vo = '{8'h00, 8'hEC, 8'hED, 8'hEC, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hC0, 8'hFF, 8'h00};
    vc = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    for (int i = 0; i < 13; i++) begin
      apply(va[i], vb[i], vs[i]);
      tests++;
      if (ALU_Out !== vo[i] || CarryOut !== vc[i]) begin
        fails++;
        $display("FAIL edge_%0d (A=%h B=%h sel=%0d): out=%h carry=%b expected %h/%b",
                 i, va[i], vb[i], vs[i], ALU_Out, CarryOut, vo[i], vc[i]);
      end
    end
  endtask

  task automatic test_input_hold;
    apply(8'h33, 8'h11, 4'd2);
    A       = 8'hFF;
    B       = 8'hFF;
    ALU_Sel = 4'd11;
    #3;
    tests++;
    if (ALU_Out !== 8'h63 || CarryOut !== 1'b0) begin
      fails++;
      $display("FAIL input_hold: out=%h carry=%b expected 63/0", ALU_Out, CarryOut);
    end
    @(posedge clk); #1;
    tests++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b1) begin
      fails++;
      $display("FAIL input_hold_next: out=%h carry=%b expected 00/1", ALU_Out, CarryOut);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [3:0] prev;
    logic [7:0] exp_o;
    logic       exp_c;
    int         bad;
    prev = ALU_Sel;
    bad  = 0;
    for (int i = 0; i < 1200; i++) begin
      a   = 8'($urandom);
      b   = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      sel = 4'(prev + 4'(1 + $urandom_range(0, 14)));
      prev = sel;
      apply(a, b, sel);
      exp_o = model_out(a, b, sel);
      exp_c = model_carry(a, b);
      tests++;
      if (ALU_Out !== exp_o || CarryOut !== exp_c) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL b2b_%0d (A=%h B=%h sel=%0d): out=%h carry=%b expected %h/%b",
                   i, a, b, sel, ALU_Out, CarryOut, exp_o, exp_c);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_opcode_sweep();
    test_edges();
    test_input_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
